// File: rtl/pdm_mic_rx.sv
// pdm_mic_rx: PDM mic clock generator and stereo L/R capture with post-enable wake-up hold-off.
// Define PDM_SYNC_EN to pass mic_data through a 2-flop synchronizer before capture.
module pdm_mic_rx #(
  parameter int CLK_DIV  = 8,
  parameter int WAKE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic mic_data,
  output logic mic_clk,
  output logic data_l,
  output logic data_r,
  output logic we,
  output logic running
);
  localparam int HALF = CLK_DIV / 2;
  localparam int DW   = $clog2(CLK_DIV);
  localparam int WW   = $clog2(WAKE_CYC + 1);

  typedef enum logic [1:0] {IDLE, WAKE, RUN} state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_div, w_div_nxt;
  logic [WW-1:0] r_wake;
  logic          r_mic_clk, r_data_l, r_data_r, r_we;
  logic          w_wrap, w_sample;

`ifdef PDM_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[0], mic_data};
  assign w_sample = r_sync[1];
`else
  assign w_sample = mic_data;
`endif

  assign w_wrap    = r_div == DW'(CLK_DIV - 1);
  assign w_div_nxt = w_wrap ? '0 : r_div + 1'b1;

  always_comb
    w_next = !en                ? IDLE :
             r_state == IDLE    ? WAKE :
             (r_state == WAKE && w_wrap && r_wake == WW'(WAKE_CYC - 1)) ? RUN : r_state;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  // mic_clk is set from the next div_cnt so it stays glitch-free across IDLE->WAKE->RUN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_div     <= '0;
      r_wake    <= '0;
      r_mic_clk <= 1'b0;
      r_data_l  <= 1'b0;
      r_data_r  <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (!en) begin
        r_mic_clk <= 1'b0;
      end else if (r_state == IDLE) begin
        r_div     <= '0;
        r_wake    <= '0;
        r_mic_clk <= 1'b1;
      end else begin
        r_div     <= w_div_nxt;
        r_mic_clk <= w_div_nxt < DW'(HALF);
        if (r_state == WAKE && w_wrap) r_wake <= r_wake + 1'b1;
        if (r_state == RUN && r_div == DW'(HALF - 1)) r_data_l <= w_sample;
        if (r_state == RUN && w_wrap) begin
          r_data_r <= w_sample;
          r_we     <= 1'b1;
        end
      end
    end

  assign mic_clk = r_mic_clk;
  assign data_l  = r_data_l;
  assign data_r  = r_data_r;
  assign we      = r_we;
  assign running = r_state == RUN;
endmodule

// File: tb/tb_pdm_mic_rx.sv
// tb_pdm_mic_rx: directed bench for pdm_mic_rx with a scoreboard of expected L/R pairs.
module tb_pdm_mic_rx;
  localparam int CD = 8;
  localparam int WC = 4;
  localparam int H  = CD / 2;
`ifdef PDM_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, en = 1'b1, mic_data = 1'b0;
  logic mic_clk, data_l, data_r, we, running;
  int   n_assert = 0, n_fail = 0, k = 0, mode = 0, n_we = 0;
  logic bl = 1'b0, br = 1'b0, sv_l, sv_r;
  logic hist [0:4095];
  logic [1:0] sb [$];

  pdm_mic_rx #(.CLK_DIV(CD), .WAKE_CYC(WC)) dut (
    .clk(clk), .rst(rst), .en(en), .mic_data(mic_data),
    .mic_clk(mic_clk), .data_l(data_l), .data_r(data_r), .we(we), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_mic_clk"}, mic_clk, 1'b0);
    chk({tag, "_data_l"},  data_l,  1'b0);
    chk({tag, "_data_r"},  data_r,  1'b0);
    chk({tag, "_we"},      we,      1'b0);
    chk({tag, "_running"}, running, 1'b0);
  endtask

  // k counts clk edges since the enable edge E0; stimulus for edge k+1 is driven after edge k
  task automatic step();
    logic [1:0] e;
    @(posedge clk);
    #1;
    chk("mic_clk", mic_clk, (k % CD) < H);
    chk("running", running, k >= WC * CD);
    chk("we", we, k >= WC * CD + CD && k % CD == 0);
    if (we === 1'b1) begin
      n_we++;
      chk("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_l", data_l, e[1]);
        chk("data_r", data_r, e[0]);
      end
    end
    if (k % CD == 0) begin
      bl = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      br = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    mic_data = mode == 2 ? k[0] : ((k % CD) < H ? bl : br);
    hist[k] = mic_data;
    if (k + 1 + D >= WC * CD + CD && (k + 1 + D) % CD == 0) sb.push_back({hist[k-4], hist[k]});
    k++;
  endtask

  initial begin
    repeat (4) begin
      @(posedge clk);
      #1;
      all_zero("reset");
    end
    rst = 1'b0;
    k = 0; n_we = 0; mode = 0;
    repeat (840) step();
    chk_int("we_count_100", n_we, 100);
    mode = 1;
    repeat (166) step();
    en = 1'b0;
    sv_l = data_l;
    sv_r = data_r;
    sb.delete();
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("dis_mic_clk", mic_clk, 1'b0);
      chk("dis_running", running, 1'b0);
      chk("dis_we", we, 1'b0);
      chk("dis_hold_l", data_l, sv_l);
      chk("dis_hold_r", data_r, sv_r);
    end
    en = 1'b1;
    k = 0; n_we = 0;
    repeat (64) step();
    chk_int("we_count_reen", n_we, 3);
    #3 rst = 1'b1;
    #1 all_zero("async_rst");
    #2 rst = 1'b0;
    sb.delete();
    k = 0; n_we = 0; mode = 2;
    repeat (80) step();
    chk_int("we_count_toggle", n_we, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
